// File: rtl/capmem_rd_ctrl_pkg.sv
// Shared constants and FSM encoding for the capture-memory reader and
// the packet generator that consumes its byte stream.
package capmem_rd_ctrl_pkg;

  localparam int DATA_W         = 96;
  localparam int OUT_W          = 8;
  localparam int ADDR_W         = 10;
  localparam int DEPTH          = 1024;
  localparam int BYTES_PER_WORD = DATA_W / OUT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/capmem_pref_fifo.sv
// Two-entry prefetch FIFO between the capture SRAM read port and the
// byte serializer. Flush empties it in one cycle.
module capmem_pref_fifo #(
  parameter int DATA_W = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] dout_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        cnt_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush_i)
    !(push_i && (cnt_q == 2'd2) && !pop_i));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst || flush_i)
    !(pop_i && (cnt_q == 2'd0)));

endmodule

// File: rtl/capmem_rd_ctrl.sv
// Capture-memory reader: fetches a window of words (wrapping at DEPTH) and
// streams them out MSB byte first, prefetching to hide the SRAM latency.
module capmem_rd_ctrl
  import capmem_rd_ctrl_pkg::*;
#(
  parameter int DATA_W = capmem_rd_ctrl_pkg::DATA_W,
  parameter int OUT_W  = capmem_rd_ctrl_pkg::OUT_W,
  parameter int ADDR_W = capmem_rd_ctrl_pkg::ADDR_W,
  parameter int DEPTH  = capmem_rd_ctrl_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_cnt,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  input  logic              out_ready
);

  localparam int                NB        = DATA_W / OUT_W;
  localparam int                IDX_W     = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NB - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;     // words not yet issued to the SRAM
  logic [ADDR_W:0]     dlv_q, dlv_d;     // words not yet loaded into the serializer
  logic                inflight_q;
  logic                done_q, done_d;
  logic                done_run_q, done_run_d;
  logic                ser_vld_q, ser_vld_d;
  logic [DATA_W-1:0]   ser_word_q, ser_word_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                ser_last_q, ser_last_d;

  logic [DATA_W-1:0]   fifo_dout;
  logic [1:0]          fifo_cnt;
  logic                fifo_push, fifo_pop, fifo_flush;
  logic                hs, word_end, last_hs, ser_free, src_avail;
  logic                load, bypass, rd_issue, start_ok;
  logic [DATA_W-1:0]   load_word;

  capmem_pref_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .din_i   (mem_rd_data),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_cnt)
  );

  always_comb begin
    hs        = ser_vld_q && out_ready;
    word_end  = hs && (idx_q == IDX_LAST);
    last_hs   = word_end && ser_last_q;
    ser_free  = !ser_vld_q || word_end;
    src_avail = (fifo_cnt != 2'd0) || inflight_q;
    start_ok  = (state_q == ST_IDLE) && start && !abort;

    // Returning data goes straight to an idle serializer when the FIFO is
    // empty; that bypass is what keeps first-byte latency at two cycles.
    load       = (state_q == ST_RUN) && !abort && ser_free && src_avail;
    bypass     = load && (fifo_cnt == 2'd0);
    load_word  = bypass ? mem_rd_data : fifo_dout;
    fifo_pop   = load && !bypass;
    fifo_push  = (state_q == ST_RUN) && !abort && inflight_q && !bypass;
    fifo_flush = abort || (state_q == ST_FLUSH);

    rd_issue = (state_q == ST_RUN) && (rem_q != '0) &&
               ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && !inflight_q));

    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && abort)             state_d = ST_FLUSH;
        else if (start && word_cnt != '0) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort)        state_d = ST_FLUSH;
        else if (last_hs) state_d = ST_IDLE;
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    addr_d = addr_q;
    rem_d  = rem_q;
    dlv_d  = dlv_q;
    if (start_ok) begin
      addr_d = base_addr;
      rem_d  = word_cnt;
      dlv_d  = word_cnt;
    end
    if (rd_issue) begin
      addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
      rem_d  = rem_q - CNT_ONE;
    end

    ser_vld_d  = ser_vld_q;
    ser_word_d = ser_word_q;
    idx_d      = idx_q;
    ser_last_d = ser_last_q;
    if (fifo_flush) begin
      ser_vld_d  = 1'b0;
      ser_word_d = '0;
      idx_d      = '0;
      ser_last_d = 1'b0;
    end else if (load) begin
      ser_vld_d  = 1'b1;
      ser_word_d = load_word;
      idx_d      = '0;
      ser_last_d = (dlv_q == CNT_ONE);
      dlv_d      = dlv_q - CNT_ONE;
    end else if (word_end) begin
      ser_vld_d = 1'b0;
      idx_d     = '0;
    end else if (hs) begin
      idx_d = idx_q + IDX_ONE;
    end

    done_run_d = (state_q == ST_RUN) && last_hs && !abort;
    done_d     = done_run_d || (start_ok && (word_cnt == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      dlv_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      done_run_q <= 1'b0;
      ser_vld_q  <= 1'b0;
      ser_word_q <= '0;
      idx_q      <= '0;
      ser_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      dlv_q      <= dlv_d;
      inflight_q <= rd_issue;
      done_q     <= done_d;
      done_run_q <= done_run_d;
      ser_vld_q  <= ser_vld_d;
      ser_word_q <= ser_word_d;
      idx_q      <= idx_d;
      ser_last_q <= ser_last_d;
    end
  end

  assign busy        = (state_q == ST_RUN) || done_run_q;
  assign done        = done_q;
  assign mem_rd_en   = rd_issue;
  assign mem_rd_addr = addr_q;
  assign out_valid   = ser_vld_q;
  assign out_last    = ser_vld_q && ser_last_q && (idx_q == IDX_LAST);
  assign out_data    = ser_word_q[(NB - 1 - int'(idx_q)) * OUT_W +: OUT_W];

endmodule

// File: tb/tb_capmem_rd_ctrl.sv
// Bench for capmem_rd_ctrl: SRAM model, stream monitor, vector table,
// randomized windows and hand-written abort/reset/latency sequences.
module tb_capmem_rd_ctrl;
  import capmem_rd_ctrl_pkg::*;

  localparam int NB = BYTES_PER_WORD;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   word_cnt = '0;
  logic              busy, done, mem_rd_en, out_valid, out_last, out_ready;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [OUT_W-1:0]  out_data;

  bit rdy_rand = 1'b0;
  bit rdy_rnd_bit = 1'b1;
  assign out_ready = rdy_rand ? rdy_rnd_bit : 1'b1;

  capmem_rd_ctrl #(
    .DATA_W (DATA_W), .OUT_W (OUT_W), .ADDR_W (ADDR_W), .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .word_cnt    (word_cnt),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  // Single-port SRAM with one cycle of read latency.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  always @(posedge clk) begin
    #1;
    rdy_rnd_bit = ($urandom_range(0, 3) != 0);
  end

  // Stream monitor, sampled on the falling edge.
  logic [7:0] got_q[$];
  bit         last_q[$];
  int         addr_log[$];
  int         done_cnt = 0, busy_cnt = 0, stab_err = 0, pref_err = 0;
  int         iss = 0, cons = 0;
  bit         stall_v = 1'b0;
  logic [7:0] stall_d = '0;

  always @(negedge clk) begin
    if (rst) begin
      iss = 0; cons = 0; stall_v = 1'b0;
    end else begin
      if (mem_rd_en) begin
        addr_log.push_back(int'(mem_rd_addr));
        iss++;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
        cons++;
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (stall_v && !(out_valid && out_data == stall_d)) stab_err++;
      stall_v = out_valid && !out_ready && !abort;
      stall_d = out_data;
      if (iss - cons / NB > 3) pref_err++;
      if (abort) begin iss = 0; cons = 0; end
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input int base, input int k);
    logic [DATA_W-1:0] w;
    w = mem[(base + k / NB) % DEPTH];
    return w[DATA_W - 1 - OUT_W * (k % NB) -: OUT_W];
  endfunction

  task automatic chk_quiet(input string nm);
    chk({nm, " ctrl"}, {busy, done, mem_rd_en, out_valid, out_last}, 0);
    chk({nm, " addr"}, mem_rd_addr, 0);
    chk({nm, " data"}, out_data, 0);
  endtask

  task automatic wait_bytes(input int g0, input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (got_q.size() - g0 >= n) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_done(input int d0, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40000; c++) begin
      if (done_cnt > d0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic chk_prefix(input string nm, input int g0, input int base);
    int bad;
    bad = 0;
    for (int k = 0; k < got_q.size() - g0; k++)
      if (got_q[g0 + k] != exp_byte(base, k)) bad++;
    chk({nm, " bytes"}, bad, 0);
  endtask

  task automatic run_window(input string nm, input int base, input int cnt,
                            input bit rnd, input int exp_n);
    int g0, a0, d0, b0, s0, p0, lerr, aerr;
    bit ok;
    g0 = got_q.size(); a0 = addr_log.size(); d0 = done_cnt;
    b0 = busy_cnt; s0 = stab_err; p0 = pref_err;
    rdy_rand  = rnd;
    base_addr = ADDR_W'(base);
    word_cnt  = (ADDR_W+1)'(cnt);
    start     = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0, ok);
    repeat (4) tick();
    rdy_rand = 1'b0;
    chk({nm, " done seen"}, ok, 1);
    chk({nm, " nbytes"}, got_q.size() - g0, exp_n);
    chk_prefix(nm, g0, base);
    lerr = 0;
    for (int k = 0; k < got_q.size() - g0; k++)
      if (last_q[g0 + k] != (k == exp_n - 1)) lerr++;
    chk({nm, " last"}, lerr, 0);
    aerr = 0;
    for (int k = 0; k < addr_log.size() - a0; k++)
      if (addr_log[a0 + k] != (base + k) % DEPTH) aerr++;
    chk({nm, " naddr"}, addr_log.size() - a0, cnt);
    chk({nm, " addr seq"}, aerr, 0);
    chk({nm, " done count"}, done_cnt - d0, 1);
    chk({nm, " busy seen"}, (busy_cnt - b0) > 0, cnt != 0);
    chk({nm, " stable"}, stab_err - s0, 0);
    chk({nm, " prefetch"}, pref_err - p0, 0);
  endtask

  typedef struct {
    string nm;
    int    base;
    int    cnt;
    bit    rnd;
    int    exp_n;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int g0, d0, b0;
    bit ok;

    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom};

    vecs[0] = '{"basic",     0,    3,    1'b0, 36};
    vecs[1] = '{"wrap",      1022, 4,    1'b0, 48};
    vecs[2] = '{"backpr",    5,    2,    1'b1, 24};
    vecs[3] = '{"zero",      7,    0,    1'b0, 0};
    vecs[4] = '{"wrap_bp",   1020, 8,    1'b1, 96};
    vecs[5] = '{"single",    500,  1,    1'b0, 12};
    vecs[6] = '{"full",      1023, 1024, 1'b0, 12288};

    rst = 1'b1;
    repeat (3) tick();
    chk_quiet("reset");
    rst = 1'b0;
    tick();

    for (int v = 0; v < 7; v++)
      run_window(vecs[v].nm, vecs[v].base, vecs[v].cnt, vecs[v].rnd, vecs[v].exp_n);

    for (int r = 0; r < 4; r++) begin
      int b, c;
      b = int'($urandom_range(0, DEPTH - 1));
      c = int'($urandom_range(1, 20));
      run_window("random", b, c, 1'b1, c * NB);
    end

    // Latency: start -> rd_en in 1 cycle, rd_en -> out_valid in 2 cycles.
    g0 = got_q.size(); d0 = done_cnt;
    base_addr = ADDR_W'(100); word_cnt = (ADDR_W+1)'(2); start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat rd_en", mem_rd_en, 1);
    chk("lat addr", mem_rd_addr, 100);
    chk("lat busy", busy, 1);
    tick();
    chk("lat valid c2", out_valid, 0);
    tick();
    chk("lat valid c3", out_valid, 1);
    chk("lat byte0", out_data, exp_byte(100, 0));
    wait_done(d0, ok);
    chk("lat done", ok, 1);
    chk("lat nbytes", got_q.size() - g0, 24);
    repeat (3) tick();

    // Second start while busy is ignored.
    g0 = got_q.size(); d0 = done_cnt;
    base_addr = ADDR_W'(200); word_cnt = (ADDR_W+1)'(3); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    base_addr = '0; word_cnt = (ADDR_W+1)'(5); start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0, ok);
    repeat (20) tick();
    chk("busy start done", ok, 1);
    chk("busy start nbytes", got_q.size() - g0, 36);
    chk_prefix("busy start", g0, 200);
    chk("busy start done count", done_cnt - d0, 1);

    // Abort mid-run.
    g0 = got_q.size(); d0 = done_cnt;
    base_addr = ADDR_W'(300); word_cnt = (ADDR_W+1)'(8); start = 1'b1;
    tick();
    start = 1'b0;
    wait_bytes(g0, 15, ok);
    chk("abort reach 15", ok, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("abort valid", out_valid, 0);
    chk("abort busy", busy, 0);
    repeat (10) tick();
    chk("abort no done", done_cnt - d0, 0);
    chk("abort stays quiet", out_valid, 0);
    chk_prefix("abort prefix", g0, 300);
    run_window("after abort", 600, 1, 1'b0, 12);

    // Abort together with start cancels the start.
    g0 = got_q.size(); d0 = done_cnt;
    base_addr = ADDR_W'(10); word_cnt = (ADDR_W+1)'(2); start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (10) tick();
    chk("start+abort bytes", got_q.size() - g0, 0);
    chk("start+abort done", done_cnt - d0, 0);

    // Abort while idle.
    b0 = busy_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    chk("idle abort busy", busy_cnt - b0, 0);
    chk("idle abort valid", out_valid, 0);

    // Reset in the middle of a run.
    g0 = got_q.size();
    base_addr = ADDR_W'(50); word_cnt = (ADDR_W+1)'(6); start = 1'b1;
    tick();
    start = 1'b0;
    wait_bytes(g0, 20, ok);
    chk("rst reach 20", ok, 1);
    rst = 1'b1;
    tick();
    chk_quiet("mid reset");
    rst = 1'b0;
    tick();
    run_window("after reset", 900, 2, 1'b1, 24);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
